// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Generic pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. It replaces the hand-written IF/ID, ID/EX, EX/MEM
// and MEM/WB latches of the 5-stage core.
//
// Back-pressure from the downstream stage (out_ready_i) never reaches
// in_ready_o combinationally: in_ready_o is a flop that depends only on
// whether the skid entry is occupied. While the main entry is stalled, one
// extra payload can still be accepted into the skid entry.
//
// A flush (or reset) empties both entries and loads NOP_VALUE into the
// payload registers, so downstream sees a bubble.
//
// Optional feature (macro PIPE_SKID_STATS_EN):
//   adds saturating stall_cnt_o / flush_cnt_o statistics counters.
//
// Parameters:
//   DATA_W     payload width in bits
//   NOP_VALUE  bubble payload driven after reset or flush
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   flush_i      squash all held entries this cycle
//   in_valid_i   upstream offers a payload
//   in_ready_o   stage can accept (registered)
//   in_data_i    upstream payload
//   out_valid_o  out_data_o holds a live payload (registered)
//   out_ready_i  downstream accepts this cycle
//   out_data_o   payload to the next stage (registered)
//   stall_cnt_o  [PIPE_SKID_STATS_EN] cycles with out_valid_o && !out_ready_i
//   flush_cnt_o  [PIPE_SKID_STATS_EN] cycles with flush_i asserted
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
   parameter int unsigned          DATA_W    = 96,
   parameter logic [DATA_W-1:0]    NOP_VALUE = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_SKID_STATS_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [15:0]       flush_cnt_o
`endif
);

   // EMPTY: nothing held. ONE: main entry live. FULL: main and skid live.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e              state_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [DATA_W-1:0]   skid_data_q;

   logic                in_xfer;
   logic                out_xfer;

   assign in_xfer  = in_valid_i && in_ready_q;
   assign out_xfer = out_valid_q && out_ready_i;

   // Single state machine; out_valid_q / in_ready_q are kept as flops next to
   // the state so both handshake outputs come straight from registers.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         // An input offered this cycle is dropped; an output transfer this
         // cycle has already been seen by the consumer.
         state_q     <= StEmpty;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_data_q  <= NOP_VALUE;
         skid_data_q <= NOP_VALUE;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_q     <= StOne;
                  out_valid_q <= 1'b1;
                  out_data_q  <= in_data_i;
               end
            end

            StOne: begin
               if (in_xfer && out_xfer) begin
                  out_data_q <= in_data_i;
               end else if (in_xfer) begin
                  // Downstream stalled: park the new payload in the skid slot.
                  state_q     <= StFull;
                  in_ready_q  <= 1'b0;
                  skid_data_q <= in_data_i;
               end else if (out_xfer) begin
                  state_q     <= StEmpty;
                  out_valid_q <= 1'b0;
               end
            end

            StFull: begin
               // in_ready_q is low here, so no input can arrive.
               if (out_xfer) begin
                  state_q    <= StOne;
                  in_ready_q <= 1'b1;
                  out_data_q <= skid_data_q;
               end
            end

            default: begin
               state_q     <= StEmpty;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               out_data_q  <= NOP_VALUE;
               skid_data_q <= NOP_VALUE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

`ifdef PIPE_SKID_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Counters saturate rather than wrap; only rst clears them, flush does not.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (out_valid_q && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic, parametrised pipeline stage register that generalises the fixed IF/ID latch.
- Carries an arbitrary-width payload with a valid/ready handshake and a 2-entry skid buffer, so back-pressure (`out_ready`) is never combinationally forwarded to `in_ready`.
- Supports flush with a programmable bubble payload.
- Instantiated between every stage of the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of hand-written stage registers.

Parameters:
- DATA_W, 96: payload width in bits (e.g. pc + instr + pc+4 = 96).
- NOP_VALUE, {DATA_W{1'b0}}: payload driven on `out_data` after reset or flush (bubble).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  squash all held entries this cycle (branch mispredict / trap).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; registered, depends only on internal state.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  `out_data` holds a live payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload to next stage; registered.

Behaviour:
- Storage: main register (`out_data`/`out_valid`) plus skid register (`skid_data`/`skid_valid`).
- Handshake terms:
  - Input transfer = `in_valid && in_ready`.
  - Output transfer = `out_valid && out_ready`.
- States:
  - EMPTY: `out_valid`=0, `skid_valid`=0.
  - ONE: `out_valid`=1, `skid_valid`=0.
  - FULL: `out_valid`=1, `skid_valid`=1.
- `in_ready` = !`skid_valid` (1 in EMPTY/ONE, 0 in FULL).
- Transitions (no flush):
  - EMPTY + in → ONE; `out_data` <= `in_data`.
  - ONE + in + out → ONE; `out_data` <= `in_data`.
  - ONE + in, no out → FULL; `skid_data` <= `in_data`.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE; `out_data` <= `skid_data` (input blocked since `in_ready`=0).
  - Any state with no transfers holds.
- Latency: 1 cycle from input transfer to `out_valid` when EMPTY. Throughput is 1 per cycle with `out_ready` held high.
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Flush, highest priority after rst:
  - Next state EMPTY; `out_data` <= NOP_VALUE; `skid_data` <= NOP_VALUE.
  - An input offered the same cycle is discarded, even if `in_ready`=1.
  - An output transfer the same cycle still completes downstream; that is the consumer's concern.
- Reset: identical to flush. Values after reset:
  - `out_valid`=0, `in_ready`=1, `out_data`=NOP_VALUE, `skid_valid`=0.
- Reset or flush asserted while FULL: both entries lost; `in_ready` returns to 1 the next cycle.
- `in_data` is sampled only on an input transfer. `out_data` is stable while `out_valid` && !`out_ready`.
- Legacy stall/flush use: tie `in_valid`=1 and drive `out_ready` = !stall.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- When defined, two extra output ports are added:
  - `stall_cnt` [31:0]: increments each cycle `out_valid` && !`out_ready`.
  - `flush_cnt` [15:0]: increments each cycle `flush`=1.
  - Both counters saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → `out_valid`=0, `in_ready`=1, `out_data`=0.
- Streaming: `out_ready`=1, push 0xA1, 0xA2, 0xA3 on consecutive cycles → each appears on `out_data` exactly 1 cycle later, `in_ready` stays 1.
- Back-pressure: `out_ready`=0, push 0xB1 then 0xB2 → FULL, `in_ready`=0. 0xB3 is held upstream. Raise `out_ready` → outputs 0xB1, 0xB2, 0xB3 in order, none lost.
- Flush while FULL (0xC1/0xC2 held) with `in_valid`=1 and `in_data`=0xC3 → next cycle `out_valid`=0, `out_data`=NOP_VALUE, `in_ready`=1; 0xC3 never appears.
- Legacy mode: `in_valid`=1, `out_ready`=!stall, stall for 3 cycles → `out_data` frozen for 3 cycles, no payload duplicated on release.
- PIPE_SKID_STATS_EN: 5 back-pressure cycles and 2 flush cycles → `stall_cnt`=5, `flush_cnt`=2. rst → both 0.
